// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared LC-3b writeback types: register/word aliases and the queued writeback entry.
package regfile_wb_arbiter_pkg;

    typedef logic [15:0] lc3b_word;
    typedef logic [2:0]  lc3b_reg;

    typedef struct packed {
        lc3b_reg  dest;
        lc3b_word data;
    } lc3b_wb_entry;

    localparam int unsigned NUM_REGS = 8;
    localparam int unsigned NUM_FWD  = 3;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input lc3b_reg r);
        return NUM_REGS'(1) << r;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus: two producer handshakes, the regfile write port and decode's forwarding lookups.
interface regfile_wb_arbiter_if;
    import regfile_wb_arbiter_pkg::*;

    logic     mem_valid;
    lc3b_reg  mem_dest;
    lc3b_word mem_data;
    logic     mem_ready;

    logic     alu_valid;
    lc3b_reg  alu_dest;
    lc3b_word alu_data;
    logic     alu_ready;

    logic     rf_load;
    lc3b_reg  rf_dest;
    lc3b_word rf_in;

    lc3b_reg  fwd_src_a;
    lc3b_reg  fwd_src_b;
    lc3b_reg  fwd_sr;
    logic     fwd_hit_a;
    logic     fwd_hit_b;
    logic     fwd_hit_sr;
    lc3b_word fwd_data_a;
    lc3b_word fwd_data_b;
    lc3b_word fwd_data_sr;

    // The arbiter side drives the regfile write port, so it is the master.
    modport master (
        input  mem_valid, mem_dest, mem_data,
        input  alu_valid, alu_dest, alu_data,
        input  fwd_src_a, fwd_src_b, fwd_sr,
        output mem_ready, alu_ready,
        output rf_load, rf_dest, rf_in,
        output fwd_hit_a, fwd_hit_b, fwd_hit_sr,
        output fwd_data_a, fwd_data_b, fwd_data_sr
    );

    modport slave (
        output mem_valid, mem_dest, mem_data,
        output alu_valid, alu_dest, alu_data,
        output fwd_src_a, fwd_src_b, fwd_sr,
        input  mem_ready, alu_ready,
        input  rf_load, rf_dest, rf_in,
        input  fwd_hit_a, fwd_hit_b, fwd_hit_sr,
        input  fwd_data_a, fwd_data_b, fwd_data_sr
    );

endinterface

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// DEPTH-entry circular buffer of writeback entries with dual push, single pop and an
// oldest-first view of every stored entry for the forwarding comparators.
module wb_fifo
    import regfile_wb_arbiter_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push0,
    input  lc3b_wb_entry    push0_entry,
    input  logic            push1,
    input  lc3b_wb_entry    push1_entry,
    input  logic            pop,
    output lc3b_wb_entry    head,
    output logic [CW-1:0]   count,
    output lc3b_wb_entry    entries [DEPTH],
    output logic [DEPTH-1:0] entry_valid
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [CW-1:0] count_q;
    lc3b_wb_entry  mem_q [DEPTH];

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (pop)
                head_q <= wrap_inc(head_q);
            if (push0 && push1)
                tail_q <= wrap_inc(wrap_inc(tail_q));
            else if (push0)
                tail_q <= wrap_inc(tail_q);
            count_q <= count_q + CW'(push0) + CW'(push1) - CW'(pop);
        end
    end

    // NOTE: storage has no reset; validity comes from head/count, so stale data is never visible.
    always_ff @(posedge clk) begin
        if (push0)
            mem_q[tail_q] <= push0_entry;
        if (push1)
            mem_q[wrap_inc(tail_q)] <= push1_entry;
    end

    assign head  = mem_q[head_q];
    assign count = count_q;

    for (genvar i = 0; i < DEPTH; i++) begin : g_view
        logic [PW:0] sum;
        assign sum            = {1'b0, head_q} + (PW+1)'(i);
        assign entries[i]     = mem_q[(sum >= (PW+1)'(DEPTH)) ? PW'(sum - (PW+1)'(DEPTH)) : PW'(sum)];
        assign entry_valid[i] = (CW'(i) < count_q);
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: merges mem and ALU results onto the single regfile write port in
// acceptance order, buffering collisions, and forwards not-yet-written values to decode.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    regfile_wb_arbiter_if.master  bus,
    output logic [CW-1:0]         count,
    output logic [NUM_REGS-1:0]   pending
);

    localparam int unsigned NC = DEPTH + 2;

    lc3b_wb_entry     mem_entry, alu_entry, rf_entry;
    lc3b_wb_entry     push0_entry, push1_entry, fifo_head;
    lc3b_wb_entry     fifo_entries [DEPTH];
    logic [DEPTH-1:0] fifo_valid;
    logic [CW-1:0]    fifo_count, slots;
    logic             mem_ready, alu_ready, mem_acc, alu_acc;
    logic             rf_load, push0, push1, pop;

    assign mem_entry = '{dest: bus.mem_dest, data: bus.mem_data};
    assign alu_entry = '{dest: bus.alu_dest, data: bus.alu_data};

    // Readiness looks only at free slots; alu reserves a second slot when mem is also offering.
    assign slots     = CW'(DEPTH) - fifo_count;
    assign mem_ready = ~reset & (slots != '0);
    assign alu_ready = ~reset & (bus.mem_valid ? (slots >= CW'(2)) : (slots != '0));
    assign mem_acc   = bus.mem_valid & mem_ready;
    assign alu_acc   = bus.alu_valid & alu_ready;

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        rf_load     = 1'b0;
        rf_entry    = fifo_head;
        pop         = 1'b0;
        push0       = 1'b0;
        push1       = 1'b0;
        push0_entry = alu_entry;
        push1_entry = alu_entry;
        if (reset) begin
            rf_load = 1'b0;
        end else if (fifo_count != '0) begin
            rf_load     = 1'b1;
            pop         = 1'b1;
            push0       = mem_acc | alu_acc;
            push0_entry = mem_acc ? mem_entry : alu_entry;
            push1       = mem_acc & alu_acc;
        end else begin
            rf_load  = mem_acc | alu_acc;
            rf_entry = mem_acc ? mem_entry : alu_entry;
            push0    = mem_acc & alu_acc;
        end
    end

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push0       (push0),
        .push0_entry (push0_entry),
        .push1       (push1),
        .push1_entry (push1_entry),
        .pop         (pop),
        .head        (fifo_head),
        .count       (fifo_count),
        .entries     (fifo_entries),
        .entry_valid (fifo_valid)
    );

    // Lookup candidates, oldest first: queued entries, then this cycle's mem, then alu.
    lc3b_wb_entry  cand [NC];
    logic [NC-1:0] cand_valid;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            cand[i]       = fifo_entries[i];
            cand_valid[i] = fifo_valid[i] & ~reset;
        end
        cand[DEPTH]         = mem_entry;
        cand_valid[DEPTH]   = mem_acc;
        cand[DEPTH+1]       = alu_entry;
        cand_valid[DEPTH+1] = alu_acc;
    end

    lc3b_reg            fwd_src  [NUM_FWD];
    lc3b_word           fwd_data [NUM_FWD];
    logic [NUM_FWD-1:0] fwd_hit;

    assign fwd_src[0] = bus.fwd_src_a;
    assign fwd_src[1] = bus.fwd_src_b;
    assign fwd_src[2] = bus.fwd_sr;

    // Scanning oldest to youngest lets the last match overwrite, so the youngest value wins.
    always_comb begin
        fwd_hit = '0;
        for (int s = 0; s < NUM_FWD; s++)
            fwd_data[s] = '0;
        for (int s = 0; s < NUM_FWD; s++) begin
            for (int c = 0; c < NC; c++) begin
                if (cand_valid[c] && (cand[c].dest == fwd_src[s])) begin
                    fwd_hit[s]  = 1'b1;
                    fwd_data[s] = cand[c].data;
                end
            end
        end
    end

    // Pending tracks entries held in the buffer; pass-through writes land at the next edge.
    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++)
            if (cand_valid[i])
                pending = pending | reg_onehot(cand[i].dest);
    end

    assign bus.mem_ready   = mem_ready;
    assign bus.alu_ready   = alu_ready;
    assign bus.rf_load     = rf_load;
    assign bus.rf_dest     = rf_entry.dest;
    assign bus.rf_in       = rf_entry.data;
    assign bus.fwd_hit_a   = fwd_hit[0];
    assign bus.fwd_hit_b   = fwd_hit[1];
    assign bus.fwd_hit_sr  = fwd_hit[2];
    assign bus.fwd_data_a  = fwd_data[0];
    assign bus.fwd_data_b  = fwd_data[1];
    assign bus.fwd_data_sr = fwd_data[2];
    assign count           = fifo_count;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus randomized traffic
// compared against an in-order list model of accepted writeback results.
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic [CW-1:0] count;
    logic [7:0]    pending;

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .count   (count),
        .pending (pending)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Model: stored = accepted but not yet written; live = stored plus this cycle's acceptances.
    lc3b_wb_entry model_q [$];
    lc3b_wb_entry nxt_q   [$];
    lc3b_wb_entry live    [$];
    lc3b_wb_entry acc_log [$];

    logic         exp_mem_ready, exp_alu_ready, exp_load;
    lc3b_wb_entry exp_wr;
    logic [7:0]   exp_pending;
    logic         exp_hit   [3];
    lc3b_word     exp_fdata [3];

    function automatic void model_fwd(input lc3b_reg src, output logic hit, output lc3b_word data);
        hit  = 1'b0;
        data = '0;
        foreach (live[i])
            if (live[i].dest == src) begin
                hit  = 1'b1;
                data = live[i].data;
            end
    endfunction

    task automatic set_src(input lc3b_reg a, input lc3b_reg b, input lc3b_reg sr);
        bus.fwd_src_a = a;
        bus.fwd_src_b = b;
        bus.fwd_sr    = sr;
    endtask

    // Drives one cycle of inputs and derives the expected outputs for that cycle.
    task automatic drive(input logic mv, input lc3b_reg md, input lc3b_word mdat,
                         input logic av, input lc3b_reg ad, input lc3b_word adat);
        int slots;
        bus.mem_valid = mv;
        bus.mem_dest  = md;
        bus.mem_data  = mdat;
        bus.alu_valid = av;
        bus.alu_dest  = ad;
        bus.alu_data  = adat;
        slots         = int'(DEPTH) - model_q.size();
        exp_mem_ready = (slots >= 1);
        exp_alu_ready = (slots >= (mv ? 2 : 1));
        exp_pending   = '0;
        foreach (model_q[i])
            exp_pending[model_q[i].dest] = 1'b1;
        if (reset) begin
            live = {};
        end else begin
            live = model_q;
            if (mv && exp_mem_ready) begin
                live.push_back('{md, mdat});
                acc_log.push_back('{md, mdat});
            end
            if (av && exp_alu_ready) begin
                live.push_back('{ad, adat});
                acc_log.push_back('{ad, adat});
            end
        end
        exp_load = (live.size() > 0);
        exp_wr   = exp_load ? live[0] : '0;
        nxt_q    = live;
        if (nxt_q.size() > 0)
            void'(nxt_q.pop_front());
        model_fwd(bus.fwd_src_a, exp_hit[0], exp_fdata[0]);
        model_fwd(bus.fwd_src_b, exp_hit[1], exp_fdata[1]);
        model_fwd(bus.fwd_sr,    exp_hit[2], exp_fdata[2]);
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    endtask

    task automatic advance();
        @(posedge clk);
        model_q = nxt_q;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_src(3'd4, 3'd5, 3'd0);
        drive(1'b1, 3'd4, 16'h5555, 1'b1, 3'd5, 16'h6666);
        @(negedge clk);
        vectors++;
        if (bus.rf_load !== 1'b0) begin
            miscompares++; $display("FAIL reset.rf_load_during got=%b exp=0", bus.rf_load);
        end
        vectors++;
        if ({bus.fwd_hit_a, bus.fwd_hit_b, bus.fwd_hit_sr} !== 3'b000) begin
            miscompares++; $display("FAIL reset.fwd_hit_during got=%b exp=000",
                                    {bus.fwd_hit_a, bus.fwd_hit_b, bus.fwd_hit_sr});
        end
        advance();
        reset = 1'b0;
        idle();
        @(negedge clk);
        vectors++;
        if (count !== CW'(0)) begin
            miscompares++; $display("FAIL reset.count got=%0d exp=0", count);
        end
        vectors++;
        if (pending !== 8'h00) begin
            miscompares++; $display("FAIL reset.pending got=%h exp=00", pending);
        end
        vectors++;
        if (bus.rf_load !== 1'b0 || bus.fwd_hit_a !== 1'b0) begin
            miscompares++; $display("FAIL reset.after got=%b%b exp=00", bus.rf_load, bus.fwd_hit_a);
        end
        vectors++;
        if (bus.mem_ready !== 1'b1 || bus.alu_ready !== 1'b1) begin
            miscompares++; $display("FAIL reset.ready got=%b%b exp=11", bus.mem_ready, bus.alu_ready);
        end
        advance();
    endtask

    task automatic test_mem_only();
        set_src(3'd3, 3'd3, 3'd3);
        drive(1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 16'h0);
        @(negedge clk);
        vectors++;
        if (bus.rf_load !== 1'b1 || bus.rf_dest !== 3'd3 || bus.rf_in !== 16'h1234) begin
            miscompares++; $display("FAIL mem_only.write got=%b/%0d/%h exp=1/3/1234",
                                    bus.rf_load, bus.rf_dest, bus.rf_in);
        end
        vectors++;
        if (bus.fwd_hit_a !== 1'b1 || bus.fwd_data_a !== 16'h1234) begin
            miscompares++; $display("FAIL mem_only.fwd got=%b/%h exp=1/1234", bus.fwd_hit_a, bus.fwd_data_a);
        end
        advance();
        idle();
        @(negedge clk);
        vectors++;
        if (count !== CW'(0) || bus.rf_load !== 1'b0) begin
            miscompares++; $display("FAIL mem_only.next got=%0d/%b exp=0/0", count, bus.rf_load);
        end
        advance();
    endtask

    task automatic test_both();
        set_src(3'd2, 3'd1, 3'd2);
        drive(1'b1, 3'd1, 16'h00AA, 1'b1, 3'd2, 16'h00BB);
        @(negedge clk);
        vectors++;
        if (bus.rf_load !== 1'b1 || bus.rf_dest !== 3'd1 || bus.rf_in !== 16'h00AA) begin
            miscompares++; $display("FAIL both.cyc0 got=%b/%0d/%h exp=1/1/00aa", bus.rf_load, bus.rf_dest, bus.rf_in);
        end
        advance();
        idle();
        @(negedge clk);
        vectors++;
        if (count !== CW'(1)) begin
            miscompares++; $display("FAIL both.count got=%0d exp=1", count);
        end
        vectors++;
        if (pending[2] !== 1'b1) begin
            miscompares++; $display("FAIL both.pending2 got=%b exp=1", pending[2]);
        end
        vectors++;
        if (bus.rf_load !== 1'b1 || bus.rf_dest !== 3'd2 || bus.rf_in !== 16'h00BB) begin
            miscompares++; $display("FAIL both.cyc1 got=%b/%0d/%h exp=1/2/00bb", bus.rf_load, bus.rf_dest, bus.rf_in);
        end
        vectors++;
        if (bus.fwd_hit_a !== 1'b1 || bus.fwd_data_a !== 16'h00BB || bus.fwd_hit_b !== 1'b0) begin
            miscompares++; $display("FAIL both.fwd got=%b/%h/%b exp=1/00bb/0", bus.fwd_hit_a, bus.fwd_data_a, bus.fwd_hit_b);
        end
        advance();
        idle();
        @(negedge clk);
        vectors++;
        if (count !== CW'(0) || pending !== 8'h00 || bus.rf_load !== 1'b0) begin
            miscompares++; $display("FAIL both.drained got=%0d/%h/%b exp=0/00/0", count, pending, bus.rf_load);
        end
        advance();
    endtask

    task automatic test_same_dest();
        set_src(3'd5, 3'd5, 3'd5);
        drive(1'b1, 3'd5, 16'h1111, 1'b1, 3'd5, 16'h2222);
        @(negedge clk);
        vectors++;
        if (bus.fwd_data_a !== 16'h2222 || bus.fwd_data_sr !== 16'h2222) begin
            miscompares++; $display("FAIL same_dest.fwd got=%h/%h exp=2222", bus.fwd_data_a, bus.fwd_data_sr);
        end
        vectors++;
        if (bus.rf_load !== 1'b1 || bus.rf_in !== 16'h1111) begin
            miscompares++; $display("FAIL same_dest.first got=%b/%h exp=1/1111", bus.rf_load, bus.rf_in);
        end
        advance();
        idle();
        @(negedge clk);
        vectors++;
        if (bus.rf_load !== 1'b1 || bus.rf_dest !== 3'd5 || bus.rf_in !== 16'h2222) begin
            miscompares++; $display("FAIL same_dest.second got=%b/%0d/%h exp=1/5/2222", bus.rf_load, bus.rf_dest, bus.rf_in);
        end
        advance();
        idle();
        @(negedge clk);
        vectors++;
        if (bus.rf_load !== 1'b0 || bus.fwd_hit_b !== 1'b0 || pending !== 8'h00) begin
            miscompares++; $display("FAIL same_dest.done got=%b/%b/%h exp=0/0/00", bus.rf_load, bus.fwd_hit_b, pending);
        end
        advance();
    endtask

    task automatic test_back_to_back();
        lc3b_wb_entry wrote [$];
        acc_log = {};
        set_src(3'd0, 3'd1, 3'd2);
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (cyc < 6)
                drive(1'b1, 3'(cyc), 16'hA000 + 16'(cyc), 1'b1, 3'(cyc + 3), 16'hB000 + 16'(cyc));
            else
                idle();
            @(negedge clk);
            vectors++;
            if (bus.mem_ready !== exp_mem_ready || bus.alu_ready !== exp_alu_ready) begin
                miscompares++; $display("FAIL b2b.ready cyc=%0d got=%b%b exp=%b%b", cyc,
                                        bus.mem_ready, bus.alu_ready, exp_mem_ready, exp_alu_ready);
            end
            vectors++;
            if (count !== CW'(model_q.size())) begin
                miscompares++; $display("FAIL b2b.count cyc=%0d got=%0d exp=%0d", cyc, count, model_q.size());
            end
            if (bus.rf_load === 1'b1)
                wrote.push_back('{bus.rf_dest, bus.rf_in});
            advance();
        end
        vectors++;
        if (wrote.size() != acc_log.size()) begin
            miscompares++; $display("FAIL b2b.write_count got=%0d exp=%0d", wrote.size(), acc_log.size());
        end else begin
            foreach (acc_log[i]) begin
                vectors++;
                if (wrote[i] !== acc_log[i]) begin
                    miscompares++; $display("FAIL b2b.order idx=%0d got=%h exp=%h", i, wrote[i], acc_log[i]);
                end
            end
        end
    endtask

    task automatic test_fwd_r7();
        set_src(3'd7, 3'd7, 3'd7);
        idle();
        @(negedge clk);
        vectors++;
        if ({bus.fwd_hit_a, bus.fwd_hit_b, bus.fwd_hit_sr} !== 3'b000 ||
            (bus.fwd_data_a | bus.fwd_data_b | bus.fwd_data_sr) !== 16'h0) begin
            miscompares++; $display("FAIL fwd_r7.miss got=%b%b%b/%h exp=000/0000", bus.fwd_hit_a,
                                    bus.fwd_hit_b, bus.fwd_hit_sr, bus.fwd_data_a | bus.fwd_data_b | bus.fwd_data_sr);
        end
        advance();
        drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd7, 16'hBEEF);
        @(negedge clk);
        vectors++;
        if ({bus.fwd_hit_a, bus.fwd_hit_b, bus.fwd_hit_sr} !== 3'b111 || bus.fwd_data_a !== 16'hBEEF ||
            bus.fwd_data_b !== 16'hBEEF || bus.fwd_data_sr !== 16'hBEEF) begin
            miscompares++; $display("FAIL fwd_r7.hit got=%b%b%b/%h/%h/%h exp=111/beef", bus.fwd_hit_a,
                                    bus.fwd_hit_b, bus.fwd_hit_sr, bus.fwd_data_a, bus.fwd_data_b, bus.fwd_data_sr);
        end
        advance();
    endtask

    task automatic test_reset_mid();
        set_src(3'd6, 3'd4, 3'd6);
        drive(1'b1, 3'd4, 16'h0A0A, 1'b1, 3'd6, 16'hDEAD);
        advance();
        reset = 1'b1;
        idle();
        @(negedge clk);
        vectors++;
        if (bus.rf_load !== 1'b0) begin
            miscompares++; $display("FAIL reset_mid.during got=%b exp=0", bus.rf_load);
        end
        advance();
        reset = 1'b0;
        for (int cyc = 0; cyc < 3; cyc++) begin
            idle();
            @(negedge clk);
            vectors++;
            if (count !== CW'(0) || pending !== 8'h00 || bus.rf_load !== 1'b0 || bus.fwd_hit_a !== 1'b0) begin
                miscompares++; $display("FAIL reset_mid.after cyc=%0d got=%0d/%h/%b/%b exp=0/00/0/0",
                                        cyc, count, pending, bus.rf_load, bus.fwd_hit_a);
            end
            advance();
        end
    endtask

    task automatic test_random();
        logic     ah [3];
        lc3b_word ad [3];
        logic     mv, av;
        for (int cyc = 0; cyc < 400; cyc++) begin
            reset = ($urandom_range(0, 39) == 0);
            mv    = ($urandom_range(0, 3) != 0);
            av    = ($urandom_range(0, 3) != 0);
            set_src(3'($urandom), 3'($urandom), 3'($urandom));
            drive(mv, 3'($urandom), 16'($urandom), av, 3'($urandom), 16'($urandom));
            @(negedge clk);
            vectors++;
            if (count !== CW'(model_q.size())) begin
                miscompares++; $display("FAIL rand.count cyc=%0d got=%0d exp=%0d", cyc, count, model_q.size());
            end
            vectors++;
            if (bus.rf_load !== exp_load) begin
                miscompares++; $display("FAIL rand.rf_load cyc=%0d got=%b exp=%b", cyc, bus.rf_load, exp_load);
            end else if (exp_load) begin
                vectors++;
                if (bus.rf_dest !== exp_wr.dest || bus.rf_in !== exp_wr.data) begin
                    miscompares++; $display("FAIL rand.rf_write cyc=%0d got=%0d/%h exp=%0d/%h",
                                            cyc, bus.rf_dest, bus.rf_in, exp_wr.dest, exp_wr.data);
                end
            end
            if (!reset) begin
                vectors++;
                if (bus.mem_ready !== exp_mem_ready || bus.alu_ready !== exp_alu_ready) begin
                    miscompares++; $display("FAIL rand.ready cyc=%0d got=%b%b exp=%b%b", cyc,
                                            bus.mem_ready, bus.alu_ready, exp_mem_ready, exp_alu_ready);
                end
            end
            if (!reset && !mv && !av) begin
                vectors++;
                if (pending !== exp_pending) begin
                    miscompares++; $display("FAIL rand.pending cyc=%0d got=%h exp=%h", cyc, pending, exp_pending);
                end
            end
            ah[0] = bus.fwd_hit_a;  ad[0] = bus.fwd_data_a;
            ah[1] = bus.fwd_hit_b;  ad[1] = bus.fwd_data_b;
            ah[2] = bus.fwd_hit_sr; ad[2] = bus.fwd_data_sr;
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (ah[k] !== exp_hit[k] || ad[k] !== exp_fdata[k]) begin
                    miscompares++; $display("FAIL rand.fwd%0d cyc=%0d got=%b/%h exp=%b/%h",
                                            k, cyc, ah[k], ad[k], exp_hit[k], exp_fdata[k]);
                end
            end
            advance();
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_mem_only();
        test_both();
        test_same_dest();
        test_back_to_back();
        test_fwd_r7();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
